sa_psum_deskew: RTL and testbench
=================================

Name: sa_psum_deskew

Overview:
- Receive-side companion to the systolic array (SA).
- Captures the diagonally skewed partial-sum rows leaving the array on psum_row_o/psum_en_row_o and re-aligns all PE_SIZE lanes into one row word.
- Buffers aligned rows in a small FIFO and hands them downstream on a valid/ready handshake, with tile-boundary marking and sticky error flags.

Parameters:
- PE_SIZE, 4, number of psum lanes (SA columns)
- PSUM_WIDTH, 32, bits per lane, two's complement
- FIFO_DEPTH, 8, aligned-row buffer entries, power of two, >=2
- ROWS, 4, rows per output tile; out_last marks the ROWS-th row

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- psum_row_i  in  PSUM_WIDTH*PE_SIZE  skewed psums from SA; lane j = bits [PSUM_WIDTH*j +: PSUM_WIDTH]
- psum_en_row_i  in  PE_SIZE  per-lane valid from SA; bit j qualifies lane j
- out_data_o  out  PSUM_WIDTH*PE_SIZE  aligned row, same lane packing
- out_valid_o  out  1  FIFO head valid
- out_ready_i  in  1  downstream accept
- out_last_o  out  1  head row is last row of tile
- err_clr_i  in  1  clears sticky errors
- err_skew_o  out  1  sticky: partial aligned row seen
- err_ovf_o  out  1  sticky: aligned row dropped, FIFO full

Behaviour:
- Skew convention:
  - Lane PE_SIZE-1 leads.
  - Lane j of a row arrives (PE_SIZE-1-j) cycles after the leading lane.
- Deskew:
  - Lane j data and enable pass through a j-stage register delay line; lane 0 has no delay.
  - Aligned vector = delayed lanes, evaluated at every rising edge.
- Aligned enable classification:
  - All ones: push row into FIFO at that edge. out_valid_o rises in the cycle after lane 0 is presented (1-cycle latency for lane 0, PE_SIZE cycles for lane PE_SIZE-1).
  - All zeros: idle.
  - Any other value: do not push; set err_skew_o.
- Delay lines shift every cycle regardless of FIFO state; no backpressure to SA.
- FIFO:
  - Registered-head, first-word-fall-through.
  - Pop when out_valid_o & out_ready_i.
  - Push when full and no pop that cycle: drop row, set err_ovf_o.
  - Push and pop in the same cycle when full: both happen, occupancy unchanged, no error.
  - Push and pop in the same cycle when empty: row written; out_valid_o next cycle.
- out_data_o and out_last_o are stable while out_valid_o is high and out_ready_i is low.
- Row counter:
  - Counts pushed rows 0..ROWS-1 and wraps to 0.
  - The push at count ROWS-1 stores last=1 alongside the row.
  - Dropped and partial rows do not advance the counter.
- Sticky errors:
  - Cleared by err_clr_i, which has priority over a set in the same cycle.
  - The error condition is re-evaluated the following cycle.
- Reset (rst high at an edge, including mid-row or mid-tile):
  - Delay lines cleared, FIFO emptied, row counter 0.
  - out_valid_o, out_last_o, err_skew_o, err_ovf_o = 0; out_data_o = 0.
  - Partially arrived rows are discarded.
  - Inputs sampled in the reset cycle are ignored.

Optional Feature:
- Macro PSUM_RELU_EN.
- Defined: each lane of out_data_o is clamped to 0 if negative (sign bit set), applied at the FIFO output. Stored data is unchanged.
- Undefined: out_data_o is the raw psum. No extra logic.

Test Plan:
- Basic align (PE_SIZE=4, out_ready_i=1):
  - Stimulus: lane3=30 @c0, lane2=20 @c1, lane1=10 @c2, lane0=5 @c3, each with only its own enable bit set.
  - Response: out_data_o={30,20,10,5}, out_valid_o high exactly in c4 for one cycle; no errors.
- Back-to-back tile, SA pattern:
  - Stimulus: enables 1000,1100,1110,1111,0111,0011,0001 with row r lane values = 16*r+j, rows 0..3.
  - Response: four consecutive valid rows in order, out_last_o=1 only on row 3.
- Backpressure / overflow (FIFO_DEPTH=8, out_ready_i=0):
  - Stimulus: 9 rows.
  - Response: 8 held with head stable; 9th dropped; err_ovf_o=1.
  - Then out_ready_i=1: rows 0..7 drain in order.
- Full with simultaneous push/pop:
  - Stimulus: FIFO full; assert out_ready_i during an incoming push.
  - Response: no drop; err_ovf_o stays 0.
- Partial skew:
  - Stimulus: suppress lane 1 of one row.
  - Response: row not pushed; err_skew_o=1 until err_clr_i; row counter unchanged.
- Reset mid-row:
  - Stimulus: assert rst after lanes 3 and 2 have arrived; later send a clean row.
  - Response: all outputs 0 after reset; the clean row emerges alone with out_last_o=0.
- PSUM_RELU_EN defined:
  - Stimulus: row {-7,3,-1,0}.
  - Response: out_data_o={0,3,0,0}.

Source files
------------

// File: rtl/sa_psum_deskew.sv
// sa_psum_deskew: receive-side deskew for the systolic array partial sums.
// Lane j of a row arrives (PE_SIZE-1-j) cycles after lane PE_SIZE-1, so lane j
// is delayed by j registers to line every lane up with lane 0. Complete rows
// go into a first-word-fall-through FIFO with a registered head and a
// tile-boundary flag. Partial rows and overflow drops raise sticky errors.
// Optional build macro: PSUM_RELU_EN clamps negative lanes to zero at the
// FIFO output. The stored data is not changed.
module sa_psum_deskew #(
   parameter int PE_SIZE    = 4,
   parameter int PSUM_WIDTH = 32,
   parameter int FIFO_DEPTH = 8,
   parameter int ROWS       = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [PSUM_WIDTH*PE_SIZE-1:0] psum_row_i,
   input  logic [PE_SIZE-1:0]            psum_en_row_i,
   output logic [PSUM_WIDTH*PE_SIZE-1:0] out_data_o,
   output logic                          out_valid_o,
   input  logic                          out_ready_i,
   output logic                          out_last_o,
   input  logic                          err_clr_i,
   output logic                          err_skew_o,
   output logic                          err_ovf_o
);

   localparam int ROW_W  = PSUM_WIDTH * PE_SIZE;
   localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
   localparam int ROWC_W = (ROWS > 1) ? $clog2(ROWS) : 1;

   genvar gi;

   // ------------------------------------------------------------------
   // Deskew delay lines
   // ------------------------------------------------------------------
   logic [PSUM_WIDTH-1:0] aligned_data [PE_SIZE];
   logic [PE_SIZE-1:0]    aligned_en;
   logic [ROW_W-1:0]      aligned_row;

   generate
      for (gi = 0; gi < PE_SIZE; gi++) begin : g_lane
         if (gi == 0) begin : g_direct
            // Lane 0 arrives last, so it is used without delay.
            assign aligned_data[gi] = psum_row_i[0 +: PSUM_WIDTH];
            assign aligned_en[gi]   = psum_en_row_i[0];
         end else begin : g_delay
            logic [PSUM_WIDTH-1:0] data_dl [gi];
            logic                  en_dl   [gi];

            // j-stage shift register. It shifts every cycle and never stalls.
            always_ff @(posedge clk) begin
               if (rst) begin
                  for (int k = 0; k < gi; k++) begin
                     data_dl[k] <= '0;
                     en_dl[k]   <= 1'b0;
                  end
               end else begin
                  data_dl[0] <= psum_row_i[PSUM_WIDTH*gi +: PSUM_WIDTH];
                  en_dl[0]   <= psum_en_row_i[gi];
                  for (int k = 1; k < gi; k++) begin
                     data_dl[k] <= data_dl[k-1];
                     en_dl[k]   <= en_dl[k-1];
                  end
               end
            end

            assign aligned_data[gi] = data_dl[gi-1];
            assign aligned_en[gi]   = en_dl[gi-1];
         end
         assign aligned_row[PSUM_WIDTH*gi +: PSUM_WIDTH] = aligned_data[gi];
      end
   endgenerate

   // A row is complete only when every aligned enable is set.
   // Any other non-zero pattern means a skew fault.
   logic row_full;
   logic row_partial;
   assign row_full    = &aligned_en;
   assign row_partial = (|aligned_en) & ~row_full;

   // ------------------------------------------------------------------
   // FIFO with registered head
   // ------------------------------------------------------------------
   logic [ROW_W-1:0] mem_data [FIFO_DEPTH];
   logic             mem_last [FIFO_DEPTH];

   logic [PTR_W-1:0]  wr_ptr_reg, rd_ptr_reg, rd_ptr_next;
   logic [CNT_W-1:0]  count_reg, count_next;
   logic              head_valid_reg;
   logic              head_last_reg;
   logic [ROW_W-1:0]  head_data_reg;
   logic [ROW_W-1:0]  head_src_data;
   logic              head_src_last;
   logic [ROWC_W-1:0] row_cnt_reg;
   logic              row_last;

   logic fifo_full;
   logic do_pop;
   logic do_push;
   logic do_drop;

   assign fifo_full = (count_reg == CNT_W'(FIFO_DEPTH));
   assign do_pop    = head_valid_reg & out_ready_i;
   // When the FIFO is full, a pop in the same cycle frees the slot the push needs.
   assign do_push   = row_full & (~fifo_full | do_pop);
   assign do_drop   = row_full & fifo_full & ~do_pop;
   assign row_last  = (row_cnt_reg == ROWC_W'(ROWS - 1));

   // Work out the next occupancy and the entry that becomes the head.
   // If the FIFO empties after this cycle's pop, the row being pushed
   // becomes the head directly. Otherwise the head comes from storage.
   always_comb begin
      rd_ptr_next   = rd_ptr_reg;
      count_next    = count_reg;
      head_src_data = '0;
      head_src_last = 1'b0;
      if (do_pop) begin
         rd_ptr_next = rd_ptr_reg + PTR_W'(1);
      end
      count_next = count_reg + CNT_W'(do_push) - CNT_W'(do_pop);
      if (do_push && (rd_ptr_next == wr_ptr_reg)) begin
         head_src_data = aligned_row;
         head_src_last = row_last;
      end else begin
         head_src_data = mem_data[rd_ptr_next];
         head_src_last = mem_last[rd_ptr_next];
      end
   end

   // Storage write port. It has no reset; the pointers decide which entries are valid.
   always_ff @(posedge clk) begin
      if (!rst && do_push) begin
         mem_data[wr_ptr_reg] <= aligned_row;
         mem_last[wr_ptr_reg] <= row_last;
      end
   end

   // Pointers, occupancy and the registered head. The head is reloaded only
   // while the FIFO stays non-empty, so it holds steady until it is popped.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_reg     <= '0;
         rd_ptr_reg     <= '0;
         count_reg      <= '0;
         head_valid_reg <= 1'b0;
         head_last_reg  <= 1'b0;
         head_data_reg  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
         end
         rd_ptr_reg     <= rd_ptr_next;
         count_reg      <= count_next;
         head_valid_reg <= (count_next != '0);
         if (count_next != '0) begin
            head_data_reg <= head_src_data;
            head_last_reg <= head_src_last;
         end else begin
            head_last_reg <= 1'b0;
         end
      end
   end

   // Row-in-tile counter. Only rows actually stored advance it.
   always_ff @(posedge clk) begin
      if (rst) begin
         row_cnt_reg <= '0;
      end else if (do_push) begin
         row_cnt_reg <= row_last ? '0 : row_cnt_reg + ROWC_W'(1);
      end
   end

   // Sticky error flags. Clear takes priority over a set in the same cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         err_skew_o <= 1'b0;
         err_ovf_o  <= 1'b0;
      end else if (err_clr_i) begin
         err_skew_o <= 1'b0;
         err_ovf_o  <= 1'b0;
      end else begin
         if (row_partial) begin
            err_skew_o <= 1'b1;
         end
         if (do_drop) begin
            err_ovf_o <= 1'b1;
         end
      end
   end

   assign out_valid_o = head_valid_reg;
   assign out_last_o  = head_last_reg;

`ifdef PSUM_RELU_EN
   // Clamp each lane to zero when its sign bit is set.
   generate
      for (gi = 0; gi < PE_SIZE; gi++) begin : g_relu
         assign out_data_o[PSUM_WIDTH*gi +: PSUM_WIDTH] =
            head_data_reg[PSUM_WIDTH*gi + PSUM_WIDTH - 1] ? '0
                                                          : head_data_reg[PSUM_WIDTH*gi +: PSUM_WIDTH];
      end
   endgenerate
`else
   assign out_data_o = head_data_reg;
`endif

endmodule

// File: tb/tb_sa_psum_deskew.sv
// Testbench for sa_psum_deskew. A scoreboard queue holds the rows expected at
// the output. A table of single rows covers data patterns and skew faults.
// Hand-written sequences cover latency, tile marking, overflow, full
// push/pop and reset in the middle of a row.
module tb_sa_psum_deskew;
   localparam int P = 4;
   localparam int W = 32;
   localparam int D = 8;
   localparam int R = 4;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic [P*W-1:0] psum_row = '0;
   logic [P-1:0]   psum_en = '0;
   logic [P*W-1:0] out_data;
   logic           out_valid;
   logic           out_ready = 1'b0;
   logic           out_last;
   logic           err_clr = 1'b0;
   logic           err_skew;
   logic           err_ovf;

   always #5 clk = ~clk;

   sa_psum_deskew #(.PE_SIZE(P), .PSUM_WIDTH(W), .FIFO_DEPTH(D), .ROWS(R)) dut (
      .clk           (clk),
      .rst           (rst),
      .psum_row_i    (psum_row),
      .psum_en_row_i (psum_en),
      .out_data_o    (out_data),
      .out_valid_o   (out_valid),
      .out_ready_i   (out_ready),
      .out_last_o    (out_last),
      .err_clr_i     (err_clr),
      .err_skew_o    (err_skew),
      .err_ovf_o     (err_ovf)
   );

   typedef struct {
      logic [P*W-1:0] data;
      logic           last;
   } exp_t;

   typedef struct {
      logic [P*W-1:0] data;
      logic [P-1:0]   mask;
      bit             exp_push;
      bit             exp_skew;
   } vec_t;

   exp_t           sb[$];
   exp_t           mon_e;
   int             checks = 0;
   int             errors = 0;
   int             row_cnt_m = 0;
   logic [P*W-1:0] rbuf [16];
   logic [P-1:0]   rmask [16];
   vec_t           vecs [6];

   function automatic logic [P*W-1:0] model_out(input logic [P*W-1:0] d);
      logic [P*W-1:0] r;
      r = d;
`ifdef PSUM_RELU_EN
      for (int j = 0; j < P; j++)
         if (d[W*j+W-1]) r[W*j +: W] = '0;
`endif
      return r;
   endfunction

   task automatic expect_row(input logic [P*W-1:0] d);
      exp_t e;
      e.data = model_out(d);
      e.last = (row_cnt_m == R-1);
      sb.push_back(e);
      row_cnt_m = (row_cnt_m + 1) % R;
   endtask

   task automatic check(input string name, input logic [P*W-1:0] act, input logic [P*W-1:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, expv);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drive rbuf[0..n-1] in the array's skewed pattern. Consecutive rows overlap.
   task automatic send_rows(input int n);
      for (int c = 0; c < n + P - 1; c++) begin
         for (int j = 0; j < P; j++) begin
            int r;
            r = c - (P - 1 - j);
            if (r >= 0 && r < n) begin
               psum_row[W*j +: W] = rbuf[r][W*j +: W];
               psum_en[j]         = rmask[r][j];
            end else begin
               psum_row[W*j +: W] = '0;
               psum_en[j]         = 1'b0;
            end
         end
         tick();
      end
      psum_row = '0;
      psum_en  = '0;
   endtask

   task automatic drain(input int max_cycles);
      out_ready = 1'b1;
      for (int i = 0; i < max_cycles && sb.size() != 0; i++) tick();
      tick();
      @(negedge clk);
      check("drain_empty", sb.size(), 0);
      check("drain_valid_low", out_valid, 1'b0);
      tick();
   endtask

   task automatic pulse_clr();
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
   endtask

   // Output monitor: one line per accepted row, compared with the scoreboard head.
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_row: got data %h last %b, nothing expected", out_data, out_last);
         end else begin
            mon_e = sb.pop_front();
            if (out_data !== mon_e.data || out_last !== mon_e.last) begin
               errors++;
               $display("FAIL row: got data %h last %b expected data %h last %b",
                        out_data, out_last, mon_e.data, mon_e.last);
            end else begin
               $display("row ok: data %h last %b", out_data, out_last);
            end
         end
      end
   end

   initial begin
      // Table entries: {lane3,lane2,lane1,lane0}, enable mask, pushed?, skew error?
      vecs[0] = '{{32'd100, 32'd200, 32'd300, 32'd400}, 4'b1111, 1'b1, 1'b0};
      vecs[1] = '{{32'd1, 32'd2, 32'd3, 32'd4}, 4'b1101, 1'b0, 1'b1};
      vecs[2] = '{{-32'sd7, 32'sd3, -32'sd1, 32'sd0}, 4'b1111, 1'b1, 1'b0};
      vecs[3] = '{{32'hDEADBEEF, 32'h12345678, 32'h0, 32'h7FFFFFFF}, 4'b1111, 1'b1, 1'b0};
      vecs[4] = '{{32'd5, 32'd6, 32'd7, 32'd8}, 4'b0111, 1'b0, 1'b1};
      vecs[5] = '{{32'd9, 32'd9, 32'd9, 32'd9}, 4'b1111, 1'b1, 1'b0};

      // Reset values
      rst = 1'b1;
      repeat (3) tick();
      rst = 1'b0;
      @(negedge clk);
      check("rst_valid", out_valid, 1'b0);
      check("rst_last", out_last, 1'b0);
      check("rst_data", out_data, '0);
      check("rst_skew", err_skew, 1'b0);
      check("rst_ovf", err_ovf, 1'b0);
      tick();

      // Basic alignment and one-cycle latency after lane 0
      out_ready = 1'b1;
      expect_row({32'd30, 32'd20, 32'd10, 32'd5});
      for (int c = 0; c < 6; c++) begin
         psum_row = '0;
         psum_en  = '0;
         if (c < P) begin
            psum_row[W*(P-1-c) +: W] = (c == 0) ? 32'd30 : (c == 1) ? 32'd20 : (c == 2) ? 32'd10 : 32'd5;
            psum_en[P-1-c] = 1'b1;
         end
         @(negedge clk);
         check($sformatf("align_valid_c%0d", c), out_valid, (c == 4));
         tick();
      end
      check("align_skew", err_skew, 1'b0);
      check("align_ovf", err_ovf, 1'b0);

      // Back-to-back tile; the counter restarts at 0 after reset
      rst = 1'b1;
      tick();
      rst = 1'b0;
      row_cnt_m = 0;
      for (int r = 0; r < R; r++) begin
         for (int j = 0; j < P; j++) rbuf[r][W*j +: W] = 32'(16*r + j);
         rmask[r] = '1;
         expect_row(rbuf[r]);
      end
      send_rows(R);
      drain(50);

      // Table-driven single rows, including partial rows
      for (int i = 0; i < 6; i++) begin
         rbuf[0]  = vecs[i].data;
         rmask[0] = vecs[i].mask;
         if (vecs[i].exp_push) expect_row(vecs[i].data);
         send_rows(1);
         repeat (2) tick();
         @(negedge clk);
         check($sformatf("vec%0d_skew", i), err_skew, vecs[i].exp_skew);
         check($sformatf("vec%0d_ovf", i), err_ovf, 1'b0);
         tick();
         pulse_clr();
         @(negedge clk);
         check($sformatf("vec%0d_skew_clr", i), err_skew, 1'b0);
         tick();
      end
      drain(50);

      // Overflow: 9 rows with ready low; the 9th is dropped
      out_ready = 1'b0;
      for (int r = 0; r < 9; r++) begin
         for (int j = 0; j < P; j++) rbuf[r][W*j +: W] = 32'(256*r + j + 1);
         rmask[r] = '1;
         if (r < D) expect_row(rbuf[r]);
      end
      send_rows(9);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check($sformatf("ovf_head_stable%0d", k), out_data, sb[0].data);
         check($sformatf("ovf_head_valid%0d", k), out_valid, 1'b1);
         tick();
      end
      @(negedge clk);
      check("ovf_flag", err_ovf, 1'b1);
      tick();
      pulse_clr();
      @(negedge clk);
      check("ovf_flag_clr", err_ovf, 1'b0);
      tick();
      drain(100);

      // Full FIFO with pop and push in the same cycle
      out_ready = 1'b0;
      for (int r = 0; r < D; r++) begin
         for (int j = 0; j < P; j++) rbuf[r][W*j +: W] = 32'(4096 + 16*r + j);
         rmask[r] = '1;
         expect_row(rbuf[r]);
      end
      send_rows(D);
      repeat (2) tick();
      expect_row({32'hA3, 32'hA2, 32'hA1, 32'hA0});
      for (int c = 0; c < P; c++) begin
         psum_row = '0;
         psum_en  = '0;
         psum_row[W*(P-1-c) +: W] = 32'(32'hA0 + (P-1-c));
         psum_en[P-1-c] = 1'b1;
         out_ready = (c == P-1);
         tick();
      end
      psum_row  = '0;
      psum_en   = '0;
      out_ready = 1'b0;
      repeat (2) tick();
      @(negedge clk);
      check("full_pushpop_ovf", err_ovf, 1'b0);
      check("full_pushpop_valid", out_valid, 1'b1);
      tick();
      drain(100);

      // Reset in the middle of a row with data and errors pending
      out_ready = 1'b0;
      for (int r = 0; r < 2; r++) begin
         rbuf[r]  = {32'h11, 32'h22, 32'h33, 32'(r)};
         rmask[r] = '1;
         expect_row(rbuf[r]);
      end
      send_rows(2);
      rbuf[0]  = '0;
      rmask[0] = 4'b1011;
      send_rows(1);
      tick();
      @(negedge clk);
      check("prerst_skew", err_skew, 1'b1);
      tick();
      psum_row[W*3 +: W] = 32'h77; psum_en[3] = 1'b1;
      tick();
      psum_row = '0; psum_en = '0;
      psum_row[W*2 +: W] = 32'h66; psum_en[2] = 1'b1;
      tick();
      psum_row = '0; psum_en = '0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      sb.delete();
      row_cnt_m = 0;
      @(negedge clk);
      check("midrst_valid", out_valid, 1'b0);
      check("midrst_last", out_last, 1'b0);
      check("midrst_data", out_data, '0);
      check("midrst_skew", err_skew, 1'b0);
      check("midrst_ovf", err_ovf, 1'b0);
      tick();
      out_ready = 1'b1;
      rbuf[0]  = {32'd44, 32'd33, 32'd22, 32'd11};
      rmask[0] = '1;
      expect_row(rbuf[0]);
      send_rows(1);
      drain(50);
      check("postrst_skew", err_skew, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
